// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives an external counter through repeated 0..limit..0 sweeps (optional overflow check: SWEEP_OVF_CHECK_EN)
module counter_sweep_ctrl #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] limit,
  input  logic [W-1:0] sweeps,
  input  logic         hold,
  input  logic         abort,
  input  logic [N-1:0] cnt_value,
  input  logic         cnt_overflow,
  output logic         cnt_en,
  output logic         cnt_clr,
  output logic         cnt_dir,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sweeps_left,
  output logic         err
);
  typedef enum logic [2:0] {IDLE, CLEAR, UP, DOWN, DONE} state_t;
  state_t state, state_d;
  logic [N-1:0] limit_q;
  logic [W-1:0] sl_d;
  logic load, ovf;
  assign load = state == IDLE && start && sweeps != '0;
`ifdef SWEEP_OVF_CHECK_EN
  assign ovf = busy && cnt_overflow;
  // sticky overflow error, cleared by the next accepted start
  always_ff @(posedge clk)
    if (!rst_n) err <= 1'b0;
    else if (load) err <= 1'b0;
    else if (ovf) err <= 1'b1;
`else
  logic unused_ovf;
  assign unused_ovf = cnt_overflow;
  assign ovf = 1'b0;
  assign err = 1'b0;
`endif
  // next state, counter controls and status; abort outranks overflow, which outranks hold
  always_comb begin
    state_d = state;
    sl_d = sweeps_left;
    cnt_en = 1'b0;
    cnt_clr = 1'b0;
    cnt_dir = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: state_d = start ? (sweeps != '0 ? CLEAR : DONE) : IDLE;
      CLEAR: begin
        busy = 1'b1;
        cnt_clr = !abort;
        state_d = UP;
      end
      UP: begin
        busy = 1'b1;
        cnt_en = !abort && !hold && cnt_value != limit_q;
        state_d = (!hold && cnt_value == limit_q) ? DOWN : UP;
      end
      DOWN: begin
        busy = 1'b1;
        cnt_dir = 1'b0;
        cnt_en = !abort && !hold && cnt_value != '0;
        if (!hold && cnt_value == '0) begin
          sl_d = sweeps_left - W'(1);
          state_d = sweeps_left == W'(1) ? DONE : UP;
        end
      end
      DONE: begin
        done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ovf) begin
      state_d = DONE;
      sl_d = sweeps_left;
    end
    if (busy && abort) begin
      state_d = IDLE;
      sl_d = sweeps_left;
    end
  end
  // state, captured limit and remaining sweep count
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      limit_q <= '0;
      sweeps_left <= '0;
    end else begin
      state <= state_d;
      sweeps_left <= load ? sweeps : sl_d;
      if (load) limit_q <= limit;
    end
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb_counter_sweep_ctrl: randomized scoreboard bench with a behavioural counter and sweep-timing model
module tb_counter_sweep_ctrl;
  logic clk = 0, rst_n = 0, start = 0, hold = 0, abort = 0, cnt_overflow = 0;
  logic [7:0] limit = 0, cnt_value = 8'd77;
  logic [3:0] sweeps = 0, sweeps_left;
  logic cnt_en, cnt_clr, cnt_dir, busy, done, err;
  int cyc = 0, checks = 0, errors = 0, tb_lim = 0, exp_sl = 0;
  bit exp_err = 0, mon_en = 0;
  logic prev_busy = 0;
  typedef struct {bit is_done; int cyc; int sl; bit err;} exp_t;
  exp_t q[$];

  counter_sweep_ctrl #(.N(8), .W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .limit(limit), .sweeps(sweeps),
    .hold(hold), .abort(abort), .cnt_value(cnt_value), .cnt_overflow(cnt_overflow),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .cnt_dir(cnt_dir), .busy(busy),
    .done(done), .sweeps_left(sweeps_left), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    cnt_value <= cnt_clr ? 8'd0 : cnt_en ? (cnt_dir ? cnt_value + 8'd1 : cnt_value - 8'd1) : cnt_value;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (cnt_en) begin
        checks++;
        if (cnt_dir ? int'(cnt_value) >= tb_lim : cnt_value == 0) begin
          errors++;
          $display("FAIL no_wrap cyc=%0d value=%0d dir=%0b limit=%0d: enable must stay low at the turning point", cyc, cnt_value, cnt_dir, tb_lim);
        end
      end
      if (done || (prev_busy && !busy)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d done=%0b busy=%0b", cyc, done, busy);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (done !== e.is_done || cyc != e.cyc || int'(sweeps_left) != e.sl || err !== e.err || busy !== 1'b0) begin
            errors++;
            $display("FAIL event got done=%0b cyc=%0d sl=%0d err=%0b busy=%0b required done=%0b cyc=%0d sl=%0d err=%0b busy=0",
                     done, cyc, sweeps_left, err, busy, e.is_done, e.cyc, e.sl, e.err);
          end
        end
      end
    end
    prev_busy <= busy;
  end

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, got, expv);
    end
  endtask

  task automatic run_cmd(input int l, input int s, input int hold_pct, input int hf, input int hl,
                         input int abort_k, input int ovf_k);
    int c0, prog, p;
    bit fin, ovf_now;
    @(posedge clk); #1;
    start = 1; limit = 8'(l); sweeps = 4'(s); hold = 0; abort = 0; c0 = cyc;
    if (s == 0) q.push_back('{1'b1, c0 + 1, exp_sl, exp_err});
    else begin
      exp_err = 0; tb_lim = l; p = 2 * (l + 1); prog = 0; fin = 0;
      for (int k = 1; !fin; k++) begin
        @(posedge clk); #1;
        start = 1'($urandom_range(1)); limit = 8'($urandom); sweeps = 4'($urandom);
        hold = (k >= hf && k < hf + hl) || ($urandom_range(99) < hold_pct);
        abort = k == abort_k;
`ifdef SWEEP_OVF_CHECK_EN
        ovf_now = k == ovf_k;
        cnt_overflow = ovf_now;
`else
        ovf_now = 0;
        cnt_overflow = $urandom_range(9) == 0;
`endif
        if (abort) begin
          exp_sl = s - (k < 2 ? 0 : prog / p);
          q.push_back('{1'b0, c0 + k + 1, exp_sl, exp_err});
          fin = 1;
        end else if (ovf_now) begin
          exp_sl = s - (k < 2 ? 0 : prog / p);
          exp_err = 1;
          q.push_back('{1'b1, c0 + k + 1, exp_sl, exp_err});
          fin = 1;
        end else if (k >= 2 && !hold) begin
          prog++;
          if (prog == s * p) begin
            exp_sl = 0;
            q.push_back('{1'b1, c0 + k + 1, exp_sl, exp_err});
            fin = 1;
          end
        end
      end
    end
    @(posedge clk); #1;
    start = 0; abort = 0; hold = 0; cnt_overflow = 0;
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
      abort = 1'($urandom_range(1)); hold = 1'($urandom_range(1));
    end
    abort = 0; hold = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_sl", sweeps_left, 0);
    chk("reset_err", err, 0); chk("reset_en", cnt_en, 0); chk("reset_clr", cnt_clr, 0);
    chk("reset_dir", cnt_dir, 1);
    @(posedge clk); #1;
    rst_n = 1; mon_en = 1;
    run_cmd(3, 2, 0, 0, 0, 0, 0);
    run_cmd(0, 3, 0, 0, 0, 0, 0);
    run_cmd(4, 0, 0, 0, 0, 0, 0);
    run_cmd(5, 1, 0, 4, 3, 0, 0);
    run_cmd(7, 3, 0, 0, 0, 6, 0);
    run_cmd(2, 0, 0, 0, 0, 0, 0);
`ifdef SWEEP_OVF_CHECK_EN
    run_cmd(4, 2, 0, 0, 0, 0, 5);
    run_cmd(1, 0, 0, 0, 0, 0, 0);
    run_cmd(1, 1, 0, 0, 0, 0, 0);
`endif
    for (int i = 0; i < 30; i++) begin
      int l, s, ak;
      l = $urandom_range(0, 6);
      s = $urandom_range(0, 3);
      ak = ($urandom_range(3) == 0 && s != 0) ? $urandom_range(1, 1 + s * 2 * (l + 1)) : 0;
      run_cmd(l, s, 20, 0, 0, ak, 0);
    end
    @(posedge clk); #1;
    start = 1; limit = 8'd3; sweeps = 4'd2; tb_lim = 3;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midreset_busy", busy, 0); chk("midreset_done", done, 0);
    chk("midreset_sl", sweeps_left, 0); chk("midreset_en", cnt_en, 0);
    @(posedge clk); #1;
    rst_n = 1; exp_sl = 0; exp_err = 0;
    run_cmd(2, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
